// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - select codes, cause codes, state and requester encodings
package mem_ctrl_pkg;

  localparam logic [2:0] SEL_PC      = 3'd0;
  localparam logic [2:0] SEL_ALU     = 3'd1;
  localparam logic [2:0] SEL_EXC_OPC = 3'd2;
  localparam logic [2:0] SEL_EXC_OVF = 3'd3;
  localparam logic [2:0] SEL_EXC_DIV = 3'd4;
  localparam logic [2:0] SEL_AUX5    = 3'd5;
  localparam logic [2:0] SEL_AUX6    = 3'd6;

  localparam logic [1:0] CAUSE_OPC = 2'd0;
  localparam logic [1:0] CAUSE_OVF = 2'd1;
  localparam logic [1:0] CAUSE_DIV = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef enum logic [1:0] {RID_NONE, RID_IF, RID_DM, RID_EXC} rid_t;

  function automatic logic [2:0] dm_sel(input logic [1:0] src);
    case (src)
      2'd1:    dm_sel = SEL_AUX5;
      2'd2:    dm_sel = SEL_AUX6;
      default: dm_sel = SEL_ALU;
    endcase
  endfunction

  // Cause 3 is an alias of div-by-zero.
  function automatic logic [2:0] exc_sel(input logic [1:0] cause);
    case (cause)
      CAUSE_OPC: exc_sel = SEL_EXC_OPC;
      CAUSE_OVF: exc_sel = SEL_EXC_OVF;
      default:   exc_sel = SEL_EXC_DIV;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - priority picker exc > dm > if; fetch-fairness counter under MEM_FAIR_ARB_EN
module mem_arb_pick
  import mem_ctrl_pkg::*;
`ifdef MEM_FAIR_ARB_EN
#(
  parameter int FAIR_LIMIT = 3
)
`endif
(
`ifdef MEM_FAIR_ARB_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       grant_en,
`endif
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       dm_wr,
  input  logic [1:0] dm_src,
  input  logic       exc_req,
  input  logic [1:0] exc_cause,
  output rid_t       gnt_id,
  output logic [2:0] gnt_sel,
  output logic       gnt_wr
);

  logic force_if;

`ifdef MEM_FAIR_ARB_EN
  logic [3:0] fair_cnt;

  assign force_if = if_req && (fair_cnt >= 4'(FAIR_LIMIT));

  // Counts dm grants that overtook a waiting fetch; exc grants leave it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fair_cnt <= 4'd0;
    end else if (grant_en) begin
      if (gnt_id == RID_IF) begin
        fair_cnt <= 4'd0;
      end else if (gnt_id == RID_DM) begin
        fair_cnt <= if_req ? fair_cnt + 4'd1 : 4'd0;
      end
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    gnt_id  = RID_NONE;
    gnt_sel = SEL_PC;
    gnt_wr  = 1'b0;
    if (exc_req) begin
      gnt_id  = RID_EXC;
      gnt_sel = exc_sel(exc_cause);
    end else if (dm_req && !force_if) begin
      gnt_id  = RID_DM;
      gnt_sel = dm_sel(dm_src);
      gnt_wr  = dm_wr;
    end else if (if_req) begin
      gnt_id  = RID_IF;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - shared memory port sequencer/arbiter; optional fetch fairness via MEM_FAIR_ARB_EN
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int FAIR_LIMIT  = 3
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       if_req,
  output logic       if_done,
  input  logic       dm_req,
  input  logic       dm_wr,
  input  logic [1:0] dm_src,
  output logic       dm_done,
  input  logic       exc_req,
  input  logic [1:0] exc_cause,
  output logic       exc_done,
  output logic [2:0] mem_addr_sel,
  output logic       mem_wr,
  output logic       busy
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("MEM_LATENCY must be in 1..15");
  end
  if (FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : g_bad_fair
    $error("FAIR_LIMIT must be in 1..15");
  end

  state_t     state;
  rid_t       lat_id;
  logic       lat_wr;
  logic [3:0] wait_cnt;
  rid_t       gnt_id;
  logic [2:0] gnt_sel;
  logic       gnt_wr;

`ifdef MEM_FAIR_ARB_EN
  logic grant_en;
  assign grant_en = (state == IDLE);

  mem_arb_pick #(
    .FAIR_LIMIT (FAIR_LIMIT)
  ) u_pick (
    .clk       (clk),
    .reset     (reset),
    .grant_en  (grant_en),
    .if_req    (if_req),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_src    (dm_src),
    .exc_req   (exc_req),
    .exc_cause (exc_cause),
    .gnt_id    (gnt_id),
    .gnt_sel   (gnt_sel),
    .gnt_wr    (gnt_wr)
  );
`else
  mem_arb_pick u_pick (
    .if_req    (if_req),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_src    (dm_src),
    .exc_req   (exc_req),
    .exc_cause (exc_cause),
    .gnt_id    (gnt_id),
    .gnt_sel   (gnt_sel),
    .gnt_wr    (gnt_wr)
  );
`endif

  // Outputs are registered from the transition, so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lat_id       <= RID_NONE;
      lat_wr       <= 1'b0;
      wait_cnt     <= 4'd0;
      mem_addr_sel <= SEL_PC;
      mem_wr       <= 1'b0;
      busy         <= 1'b0;
      if_done      <= 1'b0;
      dm_done      <= 1'b0;
      exc_done     <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      exc_done <= 1'b0;
      mem_wr   <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_id != RID_NONE) begin
            lat_id       <= gnt_id;
            lat_wr       <= gnt_wr;
            mem_addr_sel <= gnt_sel;
            mem_wr       <= gnt_wr;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_wr || MEM_LATENCY == 1) begin
            state    <= DONE;
            if_done  <= (lat_id == RID_IF);
            dm_done  <= (lat_id == RID_DM);
            exc_done <= (lat_id == RID_EXC);
          end else begin
            wait_cnt <= 4'(MEM_LATENCY - 2);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state    <= DONE;
            if_done  <= (lat_id == RID_IF);
            dm_done  <= (lat_id == RID_DM);
            exc_done <= (lat_id == RID_EXC);
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          mem_addr_sel <= SEL_PC;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed vector bench for mem_access_ctrl (latency 2 and latency 1 instances)
module tb_mem_access_ctrl;

  localparam int ID_IF  = 0;
  localparam int ID_DM  = 1;
  localparam int ID_EXC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0, exc_req = 1'b0;
  logic [1:0] dm_src = 2'd0, exc_cause = 2'd0;
  logic       if_done, dm_done, exc_done, mem_wr, busy;
  logic [2:0] mem_addr_sel;

  logic       if_req1 = 1'b0;
  logic       if_done1, dm_done1, exc_done1, mem_wr1, busy1;
  logic [2:0] mem_addr_sel1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LATENCY(2), .FAIR_LIMIT(3)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_done(if_done),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_src(dm_src), .dm_done(dm_done),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_done(exc_done),
    .mem_addr_sel(mem_addr_sel), .mem_wr(mem_wr), .busy(busy)
  );

  mem_access_ctrl #(.MEM_LATENCY(1), .FAIR_LIMIT(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_done(if_done1),
    .dm_req(1'b0), .dm_wr(1'b0), .dm_src(2'd0), .dm_done(dm_done1),
    .exc_req(1'b0), .exc_cause(2'd0), .exc_done(exc_done1),
    .mem_addr_sel(mem_addr_sel1), .mem_wr(mem_wr1), .busy(busy1)
  );

  typedef struct {
    logic       exc;
    logic [1:0] cause;
    logic       dm;
    logic       wr;
    logic [1:0] src;
    logic       ifr;
    int         id;
    logic [2:0] sel;
    logic       ewr;
    int         dc;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [7:0] obs();
    return {busy, mem_wr, mem_addr_sel, exc_done, dm_done, if_done};
  endfunction

  function automatic logic [7:0] obs1();
    return {busy1, mem_wr1, mem_addr_sel1, exc_done1, dm_done1, if_done1};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy,wr,sel,exc,dm,if=%b required %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where requests are already set; returns in the following IDLE cycle.
  task automatic check_txn(input string nm, input int id, input logic [2:0] sel, input logic wr,
                           input int dc, input logic [2:0] drop);
    logic [7:0] exp;
    for (int c = 1; c <= dc; c++) begin
      tick();
      if (c == 1) begin
        if (drop[2]) exc_req = 1'b0;
        if (drop[1]) dm_req = 1'b0;
        if (drop[0]) if_req = 1'b0;
      end
      exp = {1'b1, wr && (c == 1), sel, (id == ID_EXC) && (c == dc),
             (id == ID_DM) && (c == dc), (id == ID_IF) && (c == dc)};
      chk($sformatf("%s_c%0d", nm, c), obs(), exp);
    end
    tick();
    chk($sformatf("%s_idle", nm), obs(), 8'h00);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  int fair_ids[5];
  logic [1:0] exp1[7];

  initial begin
    //          exc  cause  dm   wr   src  if    id      sel   ewr  dc
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, ID_IF,  3'd0, 1'b0, 3};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, ID_DM,  3'd5, 1'b0, 3};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 1'b0, ID_DM,  3'd1, 1'b0, 3};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, ID_DM,  3'd1, 1'b0, 3};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0, ID_DM,  3'd6, 1'b1, 2};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, ID_DM,  3'd1, 1'b1, 2};
    vecs[6]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, ID_EXC, 3'd2, 1'b0, 3};
    vecs[7]  = '{1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, ID_EXC, 3'd3, 1'b0, 3};
    vecs[8]  = '{1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b1, ID_EXC, 3'd4, 1'b0, 3};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, ID_EXC, 3'd4, 1'b0, 3};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, ID_DM,  3'd6, 1'b0, 3};

    exp1 = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};

`ifdef MEM_FAIR_ARB_EN
    fair_ids = '{ID_DM, ID_DM, ID_DM, ID_IF, ID_DM};
`else
    fair_ids = '{ID_DM, ID_DM, ID_DM, ID_DM, ID_DM};
`endif

    #1;
    chk("reset_in", obs(), 8'h00);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("reset_rel", obs(), 8'h00);

    foreach (vecs[i]) begin
      exc_req = vecs[i].exc; exc_cause = vecs[i].cause;
      dm_req = vecs[i].dm; dm_wr = vecs[i].wr; dm_src = vecs[i].src;
      if_req = vecs[i].ifr;
      check_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].sel, vecs[i].ewr, vecs[i].dc, 3'b111);
    end

    // All three requesting: exc, then dm, then if, each released once granted.
    exc_req = 1'b1; exc_cause = 2'd1; dm_req = 1'b1; dm_wr = 1'b0; dm_src = 2'd2; if_req = 1'b1;
    check_txn("prio_exc", ID_EXC, 3'd3, 1'b0, 3, 3'b100);
    check_txn("prio_dm", ID_DM, 3'd6, 1'b0, 3, 3'b010);
    check_txn("prio_if", ID_IF, 3'd0, 1'b0, 3, 3'b001);

    // Reset asserted during WAIT aborts the fetch with no done pulse.
    if_req = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", obs(), 8'h00);
    if_req = 1'b0;
    tick();
    chk("rst_hold", obs(), 8'h00);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_quiet%0d", k), obs(), 8'h00);
    end
    if_req = 1'b1;
    check_txn("rst_fetch", ID_IF, 3'd0, 1'b0, 3, 3'b001);

    // Latency-1 instance: fetch held through done is regranted after one IDLE cycle.
    pulse_reset();
    if_req1 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 4) if_req1 = 1'b0;
      chk($sformatf("lat1_c%0d", c + 1), obs1(), {exp1[c][1], 6'b0, exp1[c][0]});
    end

    // dm and if held high continuously.
    pulse_reset();
    dm_req = 1'b1; dm_wr = 1'b0; dm_src = 2'd1; if_req = 1'b1;
    for (int g = 0; g < 5; g++) begin
      check_txn($sformatf("fair%0d", g), fair_ids[g],
                (fair_ids[g] == ID_DM) ? 3'd5 : 3'd0, 1'b0, 3, 3'b000);
    end
    dm_req = 1'b0; if_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
